// File: rtl/bridge_pkg.sv
// Shared encodings for the sram-like to AXI bridge: FSM states, access sizes,
// port ownership and the fixed AXI burst fields tied off at the top level.
package bridge_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_RD_ADDR = 3'd1;
   localparam logic [2:0] ST_RD_DATA = 3'd2;
   localparam logic [2:0] ST_WR_REQ  = 3'd3;
   localparam logic [2:0] ST_WR_RESP = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      RD_ADDR = ST_RD_ADDR,
      RD_DATA = ST_RD_DATA,
      WR_REQ  = ST_WR_REQ,
      WR_RESP = ST_WR_RESP
   } state_e;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   localparam logic [3:0] AXI_ID_FIXED   = 4'd0;
   localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe generator for single-beat 32-bit writes.
// Size 3 is not a legal access and falls through to a full word.
module axi_wstrb_gen
   import bridge_pkg::*;
(
   input  logic [1:0] size,
   input  logic [1:0] addr_lo,
   output logic [3:0] wstrb
);

   always_comb begin
      wstrb = 4'b1111;
      case (size)
         SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
         SIZE_HALF: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
         default:   wstrb = 4'b1111;
      endcase
   end

endmodule

// File: rtl/sram_like_axi_bridge.sv
// Merges the i-cache and d-cache sram-like ports onto one single-beat AXI4
// master with at most one outstanding transaction and fixed-priority grant.
module sram_like_axi_bridge
   import bridge_pkg::*;
#(
   parameter bit DATA_PRIORITY = 1'b1,
   parameter int ADDR_WIDTH    = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inst_req,
   input  logic                  inst_wr,
   input  logic [1:0]            inst_size,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   input  logic [31:0]           inst_wdata,
   output logic [31:0]           inst_rdata,
   output logic                  inst_addr_ok,
   output logic                  inst_data_ok,
   input  logic                  data_req,
   input  logic                  data_wr,
   input  logic [1:0]            data_size,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [31:0]           data_wdata,
   output logic [31:0]           data_rdata,
   output logic                  data_addr_ok,
   output logic                  data_data_ok,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [2:0]            arsize,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [31:0]           rdata,
   input  logic                  rvalid,
   output logic                  rready,
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic [2:0]            awsize,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [31:0]           wdata,
   output logic [3:0]            wstrb,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic                  bvalid,
   output logic                  bready
);

   state_e                state_q, state_d;
   logic                  owner_q, owner_d;
   logic                  wr_q, wr_d;
   logic [1:0]            size_q, size_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  aw_done_q, aw_done_d;
   logic                  w_done_q, w_done_d;
   logic                  grant_inst, grant_data, done_ok;

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      wr_d       = wr_q;
      size_d     = size_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      grant_inst = 1'b0;
      grant_data = 1'b0;
      done_ok    = 1'b0;
      case (state_q)
         IDLE: begin
            if (data_req && (!inst_req || DATA_PRIORITY)) begin
               grant_data = 1'b1;
               owner_d    = OWNER_DATA;
               wr_d       = data_wr;
               size_d     = data_size;
               addr_d     = data_addr;
               wdata_d    = data_wdata;
               state_d    = data_wr ? WR_REQ : RD_ADDR;
            end else if (inst_req) begin
               grant_inst = 1'b1;
               owner_d    = OWNER_INST;
               wr_d       = inst_wr;
               size_d     = inst_size;
               addr_d     = inst_addr;
               wdata_d    = inst_wdata;
               state_d    = inst_wr ? WR_REQ : RD_ADDR;
            end
         end
         RD_ADDR: if (arvalid && arready) state_d = RD_DATA;
         RD_DATA: begin
            if (rvalid) begin
               done_ok = 1'b1;
               state_d = IDLE;
            end
         end
         WR_REQ: begin
            // AW and W complete in any order; a same-cycle pair finishes at once
            aw_done_d = aw_done_q | (awvalid & awready);
            w_done_d  = w_done_q | (wvalid & wready);
            if (aw_done_d && w_done_d) begin
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = WR_RESP;
            end
         end
         WR_RESP: begin
            if (bvalid) begin
               done_ok = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= 1'b0;
         wr_q      <= 1'b0;
         size_q    <= 2'd0;
         addr_q    <= '0;
         wdata_q   <= 32'd0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         wr_q      <= wr_d;
         size_q    <= size_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   // Handshake outputs are masked during reset since the grant is discarded
   assign inst_addr_ok = grant_inst & ~rst;
   assign data_addr_ok = grant_data & ~rst;
   assign inst_data_ok = done_ok & ~rst & (owner_q == OWNER_INST);
   assign data_data_ok = done_ok & ~rst & (owner_q == OWNER_DATA);
   assign inst_rdata   = rdata;
   assign data_rdata   = rdata;

   assign araddr  = addr_q;
   assign arsize  = {1'b0, size_q};
   assign arvalid = (state_q == RD_ADDR) & ~wr_q;
   assign rready  = (state_q == RD_DATA);
   assign awaddr  = addr_q;
   assign awsize  = {1'b0, size_q};
   assign awvalid = (state_q == WR_REQ) & wr_q & ~aw_done_q;
   assign wvalid  = (state_q == WR_REQ) & wr_q & ~w_done_q;
   assign wdata   = wdata_q;
   assign bready  = (state_q == WR_RESP);

   axi_wstrb_gen u_wstrb (
      .size    (size_q),
      .addr_lo (addr_q[1:0]),
      .wstrb   (wstrb)
   );

endmodule

// File: tb/tb_sram_like_axi_bridge.sv
// Directed and randomized transactions against a transaction-level model of
// the bridge: grant winner, AXI channel contents, strobes and completion timing.
module tb_sram_like_axi_bridge;

   localparam bit DP = 1'b1;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic [31:0] inst_rdata, data_rdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] araddr, awaddr, rdata, wdata;
   logic [2:0]  arsize, awsize;
   logic        arvalid, arready, rvalid, rready;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [3:0]  wstrb;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   sram_like_axi_bridge #(.DATA_PRIORITY(DP), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rvalid(rvalid), .rready(rready),
      .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bready(bready)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic drive_port(input bit port, input bit req, input bit wr,
                             input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wd);
      if (port) begin
         data_req = req; data_wr = wr; data_size = size; data_addr = addr; data_wdata = wd;
      end else begin
         inst_req = req; inst_wr = wr; inst_size = size; inst_addr = addr; inst_wdata = wd;
      end
   endtask

   // Reference strobe: the access covers 2**size bytes, naturally aligned.
   function automatic logic [3:0] exp_strb(input logic [1:0] size, input logic [31:0] addr);
      int nb;
      int off;
      nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      off = (int'(addr % 4) / nb) * nb;
      return 4'(((1 << nb) - 1) << off);
   endfunction

   task automatic chk_done(input bit owner, input bit exp_ok);
      chk("owner_data_ok", owner ? data_data_ok : inst_data_ok, exp_ok);
      chk("other_data_ok", owner ? inst_data_ok : data_data_ok, 1'b0);
   endtask

   task automatic chk_no_grant;
      chk("busy_inst_addr_ok", inst_addr_ok, 1'b0);
      chk("busy_data_addr_ok", data_addr_ok, 1'b0);
   endtask

   // One complete transaction, entered and left in an IDLE cycle.
   task automatic xact(input bit owner, input bit wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int ar_dly, input int r_dly, input int aw_dly,
                       input int w_dly, input int b_dly, input logic [31:0] rd_val,
                       input bit hold_other);
      int n;
      drive_port(owner, 1'b1, wr, size, addr, wd);
      drive_port(~owner, hold_other, 1'($urandom), 2'($urandom), $urandom, $urandom);
      settle;
      chk("grant_addr_ok", owner ? data_addr_ok : inst_addr_ok, 1'b1);
      chk("loser_addr_ok", owner ? inst_addr_ok : data_addr_ok, 1'b0);
      chk_done(owner, 1'b0);
      step;
      drive_port(owner, 1'b0, 1'($urandom), 2'($urandom), $urandom, $urandom);
      if (!wr) begin
         for (int k = 0; k <= ar_dly; k++) begin
            arready = (k == ar_dly);
            settle;
            chk("arvalid", arvalid, 1'b1);
            chk("araddr", araddr, addr);
            chk("arsize", arsize, {1'b0, size});
            chk("rd_awvalid", awvalid, 1'b0);
            chk_no_grant();
            chk_done(owner, 1'b0);
            step;
         end
         arready = 1'b0;
         for (int j = 0; j <= r_dly; j++) begin
            rvalid = (j == r_dly);
            rdata  = (j == r_dly) ? rd_val : $urandom;
            settle;
            chk("rready", rready, 1'b1);
            chk("rd_arvalid", arvalid, 1'b0);
            chk_no_grant();
            chk_done(owner, j == r_dly);
            if (j == r_dly) chk("rdata", owner ? data_rdata : inst_rdata, rd_val);
            step;
         end
         rvalid = 1'b0;
      end else begin
         n = (aw_dly > w_dly) ? aw_dly : w_dly;
         for (int c = 0; c <= n; c++) begin
            awready = (c == aw_dly);
            wready  = (c == w_dly);
            settle;
            chk("awvalid", awvalid, c <= aw_dly);
            chk("wvalid", wvalid, c <= w_dly);
            if (c <= aw_dly) begin
               chk("awaddr", awaddr, addr);
               chk("awsize", awsize, {1'b0, size});
            end
            if (c <= w_dly) begin
               chk("wdata", wdata, wd);
               chk("wstrb", wstrb, exp_strb(size, addr));
            end
            chk("wr_bready", bready, 1'b0);
            chk_no_grant();
            chk_done(owner, 1'b0);
            step;
         end
         awready = 1'b0;
         wready  = 1'b0;
         for (int j = 0; j <= b_dly; j++) begin
            bvalid = (j == b_dly);
            settle;
            chk("bready", bready, 1'b1);
            chk("resp_awvalid", awvalid, 1'b0);
            chk("resp_wvalid", wvalid, 1'b0);
            chk_no_grant();
            chk_done(owner, j == b_dly);
            step;
         end
         bvalid = 1'b0;
      end
   endtask

   initial begin
      bit own;
      bit hold;
      rst = 1'b1;
      arready = 0; rvalid = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0;
      drive_port(1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'd0);
      drive_port(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      repeat (3) step;
      chk("rst_inst_addr_ok", inst_addr_ok, 1'b0);
      chk("rst_arvalid", arvalid, 1'b0);
      drive_port(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      rst = 1'b0;
      settle;
      chk("idle_arvalid", arvalid, 1'b0);
      chk("idle_awvalid", awvalid, 1'b0);
      chk("idle_wvalid", wvalid, 1'b0);
      chk("idle_rready", rready, 1'b0);
      chk("idle_bready", bready, 1'b0);
      chk_no_grant();
      chk_done(1'b1, 1'b0);
      step;

      // data word read, data arrives two cycles into the read-data phase
      xact(1'b1, 1'b0, 2'd2, 32'h1000_0004, 32'd0, 0, 2, 0, 0, 0, 32'hDEAD_BEEF, 1'b0);
      // both ports request together: data wins, inst granted straight after
      xact(1'b1, 1'b0, 2'd2, 32'h2000_0000, 32'd0, 1, 0, 0, 0, 0, 32'h1111_2222, 1'b1);
      xact(1'b0, 1'b0, 2'd2, 32'h0000_0040, 32'd0, 0, 0, 0, 0, 0, 32'h3333_4444, 1'b0);
      // byte write at offset 3, AW accepted two cycles before W
      xact(1'b1, 1'b1, 2'd0, 32'h1000_0003, 32'hAB00_0000, 0, 0, 0, 2, 1, 32'd0, 1'b0);
      xact(1'b1, 1'b1, 2'd1, 32'h1000_0006, 32'h1234_0000, 0, 0, 1, 0, 0, 32'd0, 1'b0);
      xact(1'b1, 1'b1, 2'd2, 32'h1000_0008, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 32'd0, 1'b0);
      xact(1'b1, 1'b1, 2'd3, 32'h1000_000D, 32'h5555_AAAA, 0, 0, 0, 0, 0, 32'd0, 1'b0);

      // reset in the middle of a read data phase
      drive_port(1'b1, 1'b1, 1'b0, 2'd2, 32'h2000_0008, 32'd0);
      drive_port(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      settle;
      chk("rstmid_addr_ok", data_addr_ok, 1'b1);
      step;
      drive_port(1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      arready = 1'b1;
      settle;
      chk("rstmid_arvalid", arvalid, 1'b1);
      step;
      arready = 1'b0;
      rst = 1'b1;
      settle;
      chk("rstmid_rready_before", rready, 1'b1);
      step;
      rst = 1'b0;
      rvalid = 1'b1;
      rdata = 32'h7777_7777;
      settle;
      chk("rstmid_arvalid_after", arvalid, 1'b0);
      chk("rstmid_rready_after", rready, 1'b0);
      chk_done(1'b1, 1'b0);
      chk_no_grant();
      rvalid = 1'b0;
      xact(1'b0, 1'b0, 2'd2, 32'h0000_0080, 32'd0, 0, 1, 0, 0, 0, 32'h0BAD_F00D, 1'b0);

      for (int t = 0; t < 40; t++) begin
         hold = ($urandom_range(3) == 0);
         own  = hold ? DP : 1'($urandom);
         xact(own, 1'($urandom), 2'($urandom), $urandom, $urandom,
              $urandom_range(3), $urandom_range(3), $urandom_range(3),
              $urandom_range(3), $urandom_range(3), $urandom, hold);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/sram_like_axi_bridge.md
Name: sram_like_axi_bridge

Overview:
Converts the two sram-like master ports, the i-cache side (inst_*) and the d-cache side (data_*), into one single-beat AXI4 master. It is the stage directly downstream of both caches and the only path to memory. It keeps at most one transaction outstanding and arbitrates fixed-priority between the two ports. Each request is latched at address handshake, so a cache may change its request inputs once addr_ok has been seen.

Parameters:
DATA_PRIORITY, 1, 1 means the data port wins when both ports request in the same IDLE cycle; 0 means the inst port wins.
ADDR_WIDTH, 32, width of inst/data/AXI addresses.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
{inst,data}_req  in  1  request valid, held until addr_ok
{inst,data}_wr  in  1  1 = write, 0 = read
{inst,data}_size  in  2  0 = byte, 1 = half, 2 = word
{inst,data}_addr  in  ADDR_WIDTH  byte address
{inst,data}_wdata  in  32  write data, byte lanes already aligned
{inst,data}_rdata  out  32  read data, valid with data_ok
{inst,data}_addr_ok  out  1  request accepted this cycle
{inst,data}_data_ok  out  1  transaction complete, one-cycle pulse
araddr  out  ADDR_WIDTH  AXI read address
arsize  out  3  {1'b0,size}
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  32  AXI read data
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  ADDR_WIDTH  AXI write address
awsize  out  3  {1'b0,size}
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  32  AXI write data
wstrb  out  4  byte strobes
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Reset state is IDLE.
- IDLE:
  - Grant goes to the requesting port, or to the priority port if both request.
  - The granted port's addr_ok is driven combinationally high in the same cycle. The other port's addr_ok stays 0.
  - Latched on grant: owner, wr, size, addr, wdata.
  - Next state: RD_ADDR if wr=0, WR_REQ if wr=1.
- RD_ADDR: arvalid=1 with the latched address and size. On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, the owner's data_ok=1 and owner rdata=rdata (combinational pass-through); go to IDLE.
- WR_REQ:
  - awvalid and wvalid are asserted together. Each drops independently after its own handshake, tracked by the aw_done and w_done flags.
  - Go to WR_RESP in the cycle both handshakes are complete; a same-cycle handshake on both counts.
- WR_RESP: bready=1. On bvalid, the owner's data_ok=1; go to IDLE. bresp is ignored.
- Both addr_ok outputs are 0 in every state except IDLE. There is never more than one outstanding transaction.
- The non-owner's data_ok is always 0. The non-owner's rdata is don't-care and is driven equal to rdata.
- wstrb:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: 4'b0011 << {addr[1],1'b0}.
  - size 2: 4'b1111.
  - size 3 is illegal and is treated as word.
- araddr and awaddr are passed through unmodified; the low address bits are not cleared.
- Minimum read latency: addr_ok in cycle 0, arvalid in cycle 1, earliest data_ok in cycle 2.
- Back-to-back: a new grant is possible in the cycle after data_ok, since the FSM is back in IDLE.
- A request arriving while the bridge is busy is stalled (addr_ok=0) until IDLE. The requester holds req and its inputs.
- Reset at any time:
  - Next cycle the FSM is in IDLE.
  - All valid/ready outputs, addr_ok and data_ok are 0.
  - aw_done, w_done, owner and the latched request are cleared to 0.
  - The AXI slave is reset by the same rst, so the abandoned handshake is legal.
- AXI fixed fields (id=0, len=0, burst=INCR, lock/cache/prot=0) are tied off at the top level and are not ports of this block.

Decomposition:
- Package bridge_pkg holds:
  - state encoding localparams;
  - SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2;
  - OWNER_INST=1'b0, OWNER_DATA=1'b1;
  - AXI burst/len constants.
- One sub-module, axi_wstrb_gen: combinational size + addr[1:0] -> wstrb. It is reused by the uncached path later.

Test Plan:
- data read, addr 0x1000_0004, size 2; arready on the first AR cycle; rvalid 3 cycles later with 0xDEADBEEF -> data_addr_ok in cycle 0, arvalid in cycle 1 with araddr 0x1000_0004 and arsize 3'b010, data_ok with data_rdata 0xDEADBEEF on the rvalid cycle, inst_data_ok 0 throughout.
- inst and data both request in the same cycle, DATA_PRIORITY=1 -> data_addr_ok=1, inst_addr_ok=0. The inst request is granted in the IDLE cycle after data's data_ok.
- data write sb, addr 0x...03, wdata 0xAB000000; awready 2 cycles before wready -> wstrb 4'b1000; awvalid drops after its handshake while wvalid holds; WR_RESP is entered only after the W handshake; data_ok on bvalid.
- sh at offset 2 -> wstrb 4'b1100. sw -> wstrb 4'b1111. Same-cycle awready and wready -> WR_RESP in the next cycle.
- rst asserted in RD_DATA before rvalid -> next cycle arvalid=0, rready=0, both data_ok=0, state IDLE; a new inst read is accepted right after rst deasserts.
